// File: rtl/alu_arb_pkg.sv
// alu_arbiter shared types: FSM states, ALU opcodes, datapath width.
// Build option ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins ties).
package alu_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CAPT,
    S_RESP
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_SUBU = 4'b1011;
  localparam logic [3:0] OP_ADDU = 4'b1100;

endpackage

// File: rtl/alu_arb_rr.sv
// 2-way grant: lone requester wins; on a tie the one not granted last wins.
// i_last = 1 makes requester 0 win every tie.
module alu_arb_rr (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  assign o_grant[0] = i_valid[0] & (~i_valid[1] | i_last);
  assign o_grant[1] = i_valid[1] & (~i_valid[0] | ~i_last);

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared registered ALU, one op in flight.
// Build option ALU_ARB_FIXED_PRIO_EN: req0 always wins ties (no round-robin).
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [4:0]        req0_shamt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [4:0]        req1_shamt,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [2:0]        rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [2:0]        rsp1_flags,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              busy
);

  import alu_arb_pkg::*;

  state_t            r_state;
  logic              r_id;
  logic [3:0]        r_ctrl;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [4:0]        r_shamt;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_flags;
  logic [1:0]        r_rsp_valid;

  logic [1:0] w_grant;
  logic [1:0] w_acc;
  logic       w_last;
  logic       w_rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_last = 1'b1;
`else
  logic r_last;
  assign w_last = r_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_last <= 1'b1;
    else if (|w_acc)
      r_last <= w_acc[1];
  end
`endif

  alu_arb_rr u_rr (
    .i_valid ({req1_valid, req0_valid}),
    .i_last  (w_last),
    .o_grant (w_grant)
  );

  // ready is held off while reset is high so no op is lost
  assign w_acc = (r_state == S_IDLE && !reset) ? w_grant : 2'b00;

  assign req0_ready  = w_acc[0];
  assign req1_ready  = w_acc[1];
  assign w_rsp_ready = r_id ? rsp1_ready : rsp0_ready;
  assign busy        = (r_state != S_IDLE);

  assign rsp0_valid = r_rsp_valid[0];
  assign rsp1_valid = r_rsp_valid[1];
  assign rsp0_data  = r_rsp_valid[0] ? r_data : '0;
  assign rsp1_data  = r_rsp_valid[1] ? r_data : '0;
  assign rsp0_flags = r_rsp_valid[0] ? r_flags : 3'b000;
  assign rsp1_flags = r_rsp_valid[1] ? r_flags : 3'b000;

  assign alu_control = r_ctrl;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_shamt   = r_shamt;

  // latched op registers double as the ALU drive, live only in EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_id        <= 1'b0;
      r_ctrl      <= 4'b0000;
      r_a         <= '0;
      r_b         <= '0;
      r_shamt     <= 5'd0;
      r_data      <= '0;
      r_flags     <= 3'b000;
      r_rsp_valid <= 2'b00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|w_acc) begin
            r_id    <= w_acc[1];
            r_ctrl  <= w_acc[1] ? req1_ctrl  : req0_ctrl;
            r_a     <= w_acc[1] ? req1_a     : req0_a;
            r_b     <= w_acc[1] ? req1_b     : req0_b;
            r_shamt <= w_acc[1] ? req1_shamt : req0_shamt;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_ctrl  <= 4'b0000;
          r_a     <= '0;
          r_b     <= '0;
          r_shamt <= 5'd0;
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          r_data      <= alu_result;
          r_flags     <= {alu_result[DATA_W-1],
                          alu_result == '0,
                          alu_overflow};
          r_rsp_valid <= r_id ? 2'b10 : 2'b01;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_ready) begin
            r_rsp_valid <= 2'b00;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and reference model.
// Build with ALU_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_alu_arbiter;

  import alu_arb_pkg::*;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  f;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  rv = 2'b00;
  logic [1:0]  rdy;
  logic [3:0]  rc [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic [4:0]  rs [2];
  logic [1:0]  sv;
  logic [1:0]  sr = 2'b11;
  logic [31:0] sd [2];
  logic [2:0]  sf [2];
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] tb_res = '0;
  logic        tb_ovf = 1'b0;
  logic        busy;

  exp_t        q0[$];
  exp_t        q1[$];
  int          grant_q[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [1:0]  pv = 2'b00;
  logic [31:0] last_d [2];
  logic [2:0]  last_f [2];
  bit          stop_rnd = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (rv[0]),
    .req0_ready   (rdy[0]),
    .req0_ctrl    (rc[0]),
    .req0_a       (ra[0]),
    .req0_b       (rb[0]),
    .req0_shamt   (rs[0]),
    .req1_valid   (rv[1]),
    .req1_ready   (rdy[1]),
    .req1_ctrl    (rc[1]),
    .req1_a       (ra[1]),
    .req1_b       (rb[1]),
    .req1_shamt   (rs[1]),
    .rsp0_valid   (sv[0]),
    .rsp0_ready   (sr[0]),
    .rsp0_data    (sd[0]),
    .rsp0_flags   (sf[0]),
    .rsp1_valid   (sv[1]),
    .rsp1_ready   (sr[1]),
    .rsp1_data    (sd[1]),
    .rsp1_flags   (sf[1]),
    .alu_control  (alu_control),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_shamt    (alu_shamt),
    .alu_result   (tb_res),
    .alu_overflow (tb_ovf),
    .busy         (busy)
  );

  // behavioural ALU: {overflow, result}; signed overflow from wide arithmetic
  function automatic logic [32:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [4:0] sh);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    logic [31:0] r = '0;
    logic o = 1'b0;
    case (op)
      OP_ADD: begin
        s = sa + sb; r = a + b;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUB: begin
        s = sa - sb; r = a - b;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_NOR:  r = ~(a | b);
      OP_SUBU: r = a - b;
      OP_ADDU: r = a + b;
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  always @(posedge clk)
    {tb_ovf, tb_res} <= alu_ref(alu_control, alu_a, alu_b, alu_shamt);

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic issue(input int n, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    logic [32:0] r;
    exp_t e;
    int k;
    rc[n] = op; ra[n] = a; rb[n] = b; rs[n] = sh; rv[n] = 1'b1;
    r = alu_ref(op, a, b, sh);
    e.d = r[31:0];
    e.f = {r[31], r[31:0] == 32'd0, r[32]};
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rdy[n]) break;
    end
    if (k == 300) begin
      n_total++;
      $display("FAIL accept%0d: no ready within 300 cycles", n);
      rv[n] = 1'b0;
      return;
    end
    e.cyc = cyc;
    if (n == 0) q0.push_back(e);
    else q1.push_back(e);
    grant_q.push_back(n);
    @(posedge clk); #1;
    rv[n] = 1'b0;
  endtask

  task automatic issue_rnd(input int n);
    issue(n, 4'($urandom_range(0, 15)), $urandom, $urandom,
          5'($urandom_range(0, 31)));
  endtask

  task automatic drain();
    for (int k = 0; k < 600; k++) begin
      if (rv == 2'b00 && q0.size() == 0 && q1.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
    end
    n_total++;
    $display("FAIL drain: q0=%0d q1=%0d left after 600 cycles",
             q0.size(), q1.size());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rv = 2'b00;
    q0.delete(); q1.delete(); grant_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // monitor: latency on rising rsp valid, data/flags on each handshake
  always @(negedge clk) begin
    if (reset) begin
      pv = 2'b00;
    end else begin
      chk("ready_onehot", {63'd0, rdy == 2'b11}, 64'd0);
      if (busy) chk("ready_busy", {62'd0, rdy}, 64'd0);
      else chk("alu_idle", {alu_control, alu_a, alu_b, alu_shamt} != '0, 0);
      for (int n = 0; n < 2; n++) begin
        exp_t e;
        int sz;
        sz = (n == 0) ? q0.size() : q1.size();
        if (sv[n] && sz == 0) begin
          n_total++;
          $display("FAIL rsp%0d: unexpected response data %0h", n, sd[n]);
        end else if (sv[n]) begin
          e = (n == 0) ? q0[0] : q1[0];
          if (!pv[n]) chk($sformatf("latency%0d", n), cyc - e.cyc, 3);
          if (sr[n]) begin
            chk($sformatf("data%0d", n), sd[n], e.d);
            chk($sformatf("flags%0d", n), sf[n], e.f);
            last_d[n] = sd[n];
            last_f[n] = sf[n];
            if (n == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
          end
        end
      end
      pv = sv;
    end
  end

  initial begin
    logic [31:0] hold;
    int exp_g [4];
    for (int n = 0; n < 2; n++) begin
      rc[n] = '0; ra[n] = '0; rb[n] = '0; rs[n] = '0;
    end
    // reset values with valids asserted
    reset = 1'b1;
    rv = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_rsp", sv, 0);
    chk("rst_alu", {alu_control, alu_a, alu_b, alu_shamt}, 0);
    rv = 2'b00;
    @(posedge clk); #1 reset = 1'b0;

    // single ADD 5+7
    issue(0, OP_ADD, 32'd5, 32'd7, 5'd0);
    drain();
    chk("add_data", last_d[0], 12);
    chk("add_flags", last_f[0], 3'b000);

    // simultaneous after reset: req0 first
    do_reset();
    fork
      issue(0, OP_SUB, 32'd3, 32'd3, 5'd0);
      issue(1, OP_ADD, 32'd1, 32'd1, 5'd0);
    join
    drain();
    chk("tie_first", grant_q[0], 0);
    chk("tie_second", grant_q[1], 1);
    chk("sub_data", last_d[0], 0);
    chk("sub_flags", last_f[0], 3'b010);
    chk("add1_data", last_d[1], 2);

    // continuous contention, four grants
    do_reset();
    fork
      repeat (4) issue_rnd(0);
      repeat (4) issue_rnd(1);
    join
    drain();
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g[i] = 0;
`else
      exp_g[i] = i % 2;
`endif
      chk($sformatf("order%0d", i), grant_q[i], exp_g[i]);
    end

    // rsp1 back-pressure with req0 waiting
    do_reset();
    sr[1] = 1'b0;
    issue(1, OP_OR, $urandom, $urandom, 5'd0);
    fork
      issue(0, OP_XOR, $urandom, $urandom, 5'd0);
    join_none
    for (int k = 0; k < 10 && !sv[1]; k++) @(negedge clk);
    chk("bp_valid", sv[1], 1);
    hold = sd[1];
    repeat (10) begin
      @(negedge clk);
      chk("bp_stable", sd[1], hold);
      chk("bp_busy", busy, 1);
      chk("bp_req0", rdy[0], 0);
    end
    sr[1] = 1'b1;
    drain();

    // reset while capturing
    issue(0, OP_ADD, $urandom, $urandom, 5'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_rsp", sv, 0);
    q0.delete(); q1.delete(); grant_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    issue(1, OP_SUB, 32'd100, 32'd58, 5'd0);
    drain();
    chk("post_rst_data", last_d[1], 42);

    // randomized traffic with random response back-pressure
    fork
      begin
        while (!stop_rnd) begin
          @(posedge clk); #1;
          sr = 2'($urandom);
        end
      end
    join_none
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #1 issue_rnd(0);
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #1 issue_rnd(1);
      end
    join
    stop_rnd = 1;
    @(posedge clk); #2;
    sr = 2'b11;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 clk  in  1  clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 reqN_valid (N=0,1)  in  1  requester N presents an op.
REQ-005 reqN_ready  out  1  op accepted this cycle when high with reqN_valid.
REQ-006 reqN_ctrl  in  4  ALU opcode.
REQ-007 reqN_a  in  32  operand A.
REQ-008 reqN_b  in  32  operand B.
REQ-009 reqN_shamt  in  5  shift amount.
REQ-010 rspN_valid  out  1  result for requester N available.
REQ-011 rspN_ready  in  1  requester N consumes result.
REQ-012 rspN_data  out  32  ALU result.
REQ-013 rspN_flags  out  3  {less, zero, overflow}.
REQ-014 alu_control  out  4  opcode to shared registered ALU.
REQ-015 alu_a / alu_b  out  32  operands to ALU.
REQ-016 alu_shamt  out  5  shift amount to ALU.
REQ-017 alu_result  in  32  ALU registered result, valid one cycle after operands presented.
REQ-018 alu_overflow  in  1  ALU overflow.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states IDLE, EXEC, CAPT, RESP; one op in flight at a time.
REQ-021 IDLE: any reqN_valid -> grant one, assert its reqN_ready combinationally same cycle, latch ctrl/a/b/shamt and grant id, go EXEC; never both readys high.
REQ-022 Simultaneous valid: grant requester opposite to last_grant; last_grant updates on every grant.
REQ-023 EXEC: drive alu_* from latched op for exactly one cycle, go CAPT.
REQ-024 Outside EXEC: alu_control = 4'b0000, alu_a/alu_b/alu_shamt = 0.
REQ-025 CAPT: latch alu_result, alu_overflow; zero = (alu_result == 0); less = alu_result[31]; go RESP.
REQ-026 RESP: rspN_valid high for granted N only, data/flags stable until rspN_ready; on rspN_ready go IDLE.
REQ-027 Latency: acceptance edge T0 -> rspN_valid high in cycle T0+3; minimum 4 cycles between acceptances.
REQ-028 Requests arriving outside IDLE wait; reqN_ready low; no drop, no reordering per requester.
REQ-029 rspN_ready while rspN_valid low is ignored.
REQ-030 Opcode not range-checked; unknown opcodes pass through, ALU yields 0.

Reset
REQ-031 Reset (incl. mid-operation) -> IDLE, in-flight op discarded, last_grant = 1 (req0 wins first tie), all outputs 0, busy 0.
REQ-032 First grant possible in the first cycle after reset deasserts.

Configuration
REQ-033 ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties, last_grant unused; undefined: round-robin per REQ-022.

Structure
REQ-034 Package alu_arb_pkg: FSM state enum, ALU opcode constants (ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110, NOT 0111, SLL 1000, SRL 1001, NOR 1010, SUBU 1011, ADDU 1100), DATA_W.
REQ-035 Sub-module alu_arb_rr: 2-way grant logic (valids, last_grant -> one-hot grant).

Verification
REQ-036 req0 ADD a=5 b=7 alone -> req0_ready T0, rsp0_valid T3, data 12, flags 3'b000.
REQ-037 Both valid same cycle after reset, req0 SUB 3-3, req1 ADD 1+1 -> req0 first: data 0, zero=1; then req1 data 2.
REQ-038 Both valid continuously 4 ops -> grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-039 rsp1_ready held low 10 cycles in RESP -> rsp1_data stable, busy=1, req0_ready stays 0.
REQ-040 Reset asserted in CAPT -> next cycle busy=0, rspN_valid=0; next op result correct.
